// File: rtl/ysyx_220066_decode_queue.sv
// ysyx_220066_decode_queue
//   Decode stage of the RV64IM pipeline, built as a DEPTH-entry queue of
//   fully decoded instruction packets. Instructions are decoded when they
//   are enqueued, so EX consumes a ready-made packet from the queue head.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous flush: drops every entry and any same-cycle push
//   in_valid/in_ready IF-side handshake (in_ready = queue not full)
//   in_instr, in_pc   raw instruction and its PC
//   in_fetch_err      fetch access fault for this instruction
//   in_csr_err        addressed CSR is nonexistent or read-only
//   out_valid/out_ready EX-side handshake (out_valid = queue not empty)
//   out_*             decoded packet fields of the head entry
//   out_exc, out_exc_cause  head exception flag and mcause code
//   out_count         current occupancy
module ysyx_220066_decode_queue #(
  parameter int DEPTH     = 4,
  parameter int XLEN      = 64,
  parameter bit CSR_CHECK = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  input  logic                    in_fetch_err,
  input  logic                    in_csr_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_imm,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic                    out_regwr,
  output logic                    out_memrd,
  output logic                    out_memwr,
  output logic [2:0]              out_memop,
  output logic [2:0]              out_branch,
  output logic                    out_aluasrc,
  output logic [1:0]              out_alubsrc,
  output logic [4:0]              out_aluctr,
  output logic                    out_is_mul,
  output logic                    out_is_div,
  output logic                    out_is_ex,
  output logic                    out_csr,
  output logic                    out_ecall,
  output logic                    out_ebreak,
  output logic                    out_mret,
  output logic                    out_exc,
  output logic [3:0]              out_exc_cause,
  output logic [$clog2(DEPTH):0]  out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Immediate format selectors
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_J = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b101;

  // Opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  // ALU operation codes; bit 4 selects the 32-bit (W) variant
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_COPYB = 5'd10;
  localparam logic [4:0] ALU_ADDW  = 5'd16;
  localparam logic [4:0] ALU_SUBW  = 5'd17;
  localparam logic [4:0] ALU_SLLW  = 5'd18;
  localparam logic [4:0] ALU_SRLW  = 5'd22;
  localparam logic [4:0] ALU_SRAW  = 5'd23;

  // ALU B source: register, immediate, or the constant 4 for link addresses
  localparam logic [1:0] BSRC_RS2  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_FOUR = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            regwr;
    logic            memrd;
    logic            memwr;
    logic [2:0]      memop;
    logic [2:0]      branch;
    logic            aluasrc;
    logic [1:0]      alubsrc;
    logic [4:0]      aluctr;
    logic            is_mul;
    logic            is_div;
    logic            is_ex;
    logic            csr;
    logic            ecall;
    logic            ebreak;
    logic            mret;
    logic            exc;
    logic [3:0]      exc_cause;
  } pkt_t;

  function automatic logic [4:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_of_f3 = ALU_ADD;
      3'b001:  alu_of_f3 = ALU_SLL;
      3'b010:  alu_of_f3 = ALU_SLT;
      3'b011:  alu_of_f3 = ALU_SLTU;
      3'b100:  alu_of_f3 = ALU_XOR;
      3'b101:  alu_of_f3 = ALU_SRL;
      3'b110:  alu_of_f3 = ALU_OR;
      default: alu_of_f3 = ALU_AND;
    endcase
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [2:0]  w_imm_type;
  logic [31:0] w_imm32;
  logic        w_regwr, w_memrd, w_memwr, w_aluasrc;
  logic [2:0]  w_branch;
  logic [1:0]  w_alubsrc;
  logic [4:0]  w_aluctr;
  logic        w_is_mul, w_is_div, w_csr, w_illegal;
  logic        w_ecall, w_ebreak, w_mret;
  pkt_t        w_pkt;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_ecall  = (in_instr == INSTR_ECALL);
  assign w_ebreak = (in_instr == INSTR_EBREAK);
  assign w_mret   = (in_instr == INSTR_MRET);

  // Control decode. Any opcode whose low two bits are not 11 falls into the
  // default arm and is therefore illegal.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_imm_type = IMM_I;
    w_regwr    = 1'b0;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_branch   = 3'b000;
    w_aluasrc  = 1'b0;
    w_alubsrc  = BSRC_RS2;
    w_aluctr   = ALU_ADD;
    w_is_mul   = 1'b0;
    w_is_div   = 1'b0;
    w_csr      = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_imm_type = IMM_U; w_regwr = 1'b1; w_alubsrc = BSRC_IMM; w_aluctr = ALU_COPYB;
      end
      OP_AUIPC: begin
        w_imm_type = IMM_U; w_regwr = 1'b1; w_aluasrc = 1'b1; w_alubsrc = BSRC_IMM;
      end
      OP_JAL: begin
        w_imm_type = IMM_J; w_regwr = 1'b1; w_branch = 3'b001;
        w_aluasrc = 1'b1; w_alubsrc = BSRC_FOUR;
      end
      OP_JALR: begin
        if (w_f3 != 3'b000) w_illegal = 1'b1;
        w_regwr = 1'b1; w_branch = 3'b010; w_aluasrc = 1'b1; w_alubsrc = BSRC_FOUR;
      end
      OP_BRANCH: begin
        w_imm_type = IMM_B;
        // Low branch-code bits: 00 eq, 01 ne, 10 lt, 11 ge; signedness in aluctr
        case (w_f3)
          3'b000:  begin w_branch = 3'b100; w_aluctr = ALU_SUB;  end
          3'b001:  begin w_branch = 3'b101; w_aluctr = ALU_SUB;  end
          3'b100:  begin w_branch = 3'b110; w_aluctr = ALU_SLT;  end
          3'b101:  begin w_branch = 3'b111; w_aluctr = ALU_SLT;  end
          3'b110:  begin w_branch = 3'b110; w_aluctr = ALU_SLTU; end
          3'b111:  begin w_branch = 3'b111; w_aluctr = ALU_SLTU; end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        if (w_f3 == 3'b111) w_illegal = 1'b1;
        w_regwr = 1'b1; w_memrd = 1'b1; w_alubsrc = BSRC_IMM;
      end
      OP_STORE: begin
        if (w_f3[2]) w_illegal = 1'b1;
        w_imm_type = IMM_S; w_memwr = 1'b1; w_alubsrc = BSRC_IMM;
      end
      OP_IMM: begin
        w_regwr = 1'b1; w_alubsrc = BSRC_IMM; w_aluctr = alu_of_f3(w_f3);
        // RV64 shifts carry a 6-bit shamt, so only instr[31:26] is funct
        if (w_f3 == 3'b001 && in_instr[31:26] != 6'b000000) w_illegal = 1'b1;
        if (w_f3 == 3'b101) begin
          if (in_instr[31:26] == 6'b010000) w_aluctr = ALU_SRA;
          else if (in_instr[31:26] != 6'b000000) w_illegal = 1'b1;
        end
      end
      OP_IMM32: begin
        w_regwr = 1'b1; w_alubsrc = BSRC_IMM;
        case (w_f3)
          3'b000: w_aluctr = ALU_ADDW;
          3'b001: begin
            w_aluctr = ALU_SLLW;
            if (w_f7 != 7'b0000000) w_illegal = 1'b1;
          end
          3'b101: begin
            if (w_f7 == 7'b0000000) w_aluctr = ALU_SRLW;
            else if (w_f7 == 7'b0100000) w_aluctr = ALU_SRAW;
            else w_illegal = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_REG: begin
        w_regwr = 1'b1;
        case (w_f7)
          7'b0000000: w_aluctr = alu_of_f3(w_f3);
          7'b0100000: begin
            if (w_f3 == 3'b000) w_aluctr = ALU_SUB;
            else if (w_f3 == 3'b101) w_aluctr = ALU_SRA;
            else w_illegal = 1'b1;
          end
          7'b0000001: begin
            w_is_mul = ~w_f3[2]; w_is_div = w_f3[2]; w_aluctr = {2'b00, w_f3};
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_REG32: begin
        w_regwr = 1'b1;
        case (w_f7)
          7'b0000000: begin
            if (w_f3 == 3'b000) w_aluctr = ALU_ADDW;
            else if (w_f3 == 3'b001) w_aluctr = ALU_SLLW;
            else if (w_f3 == 3'b101) w_aluctr = ALU_SRLW;
            else w_illegal = 1'b1;
          end
          7'b0100000: begin
            if (w_f3 == 3'b000) w_aluctr = ALU_SUBW;
            else if (w_f3 == 3'b101) w_aluctr = ALU_SRAW;
            else w_illegal = 1'b1;
          end
          7'b0000001: begin
            // Only mulw and the four divide/remainder W forms exist
            if (w_f3 != 3'b000 && !w_f3[2]) w_illegal = 1'b1;
            w_is_mul = ~w_f3[2]; w_is_div = w_f3[2]; w_aluctr = {2'b10, w_f3};
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_FENCE: begin
        if (w_f3[2:1] != 2'b00) w_illegal = 1'b1;
      end
      OP_SYSTEM: begin
        if (w_f3 == 3'b000) begin
          if (!(w_ecall || w_ebreak || w_mret)) w_illegal = 1'b1;
        end else if (w_f3 == 3'b100) begin
          w_illegal = 1'b1;
        end else if (CSR_CHECK && in_csr_err) begin
          w_illegal = 1'b1;
        end else begin
          w_csr = 1'b1; w_regwr = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    // A faulting or illegal instruction must not write state or redirect flow
    if (in_fetch_err || w_illegal) begin
      w_regwr  = 1'b0;
      w_memrd  = 1'b0;
      w_memwr  = 1'b0;
      w_branch = 3'b000;
    end
  end

  always_comb begin
    case (w_imm_type)
      IMM_U:   w_imm32 = {in_instr[31:12], 12'b0};
      IMM_B:   w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_S:   w_imm32 = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
      IMM_J:   w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
    endcase
  end

  always_comb begin
    w_pkt           = '0;
    w_pkt.pc        = in_pc;
    w_pkt.imm       = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    w_pkt.rd        = in_instr[11:7];
    w_pkt.rs1       = in_instr[19:15];
    w_pkt.rs2       = in_instr[24:20];
    w_pkt.regwr     = w_regwr;
    w_pkt.memrd     = w_memrd;
    w_pkt.memwr     = w_memwr;
    w_pkt.memop     = w_f3;
    w_pkt.branch    = w_branch;
    w_pkt.aluasrc   = w_aluasrc;
    w_pkt.alubsrc   = w_alubsrc;
    w_pkt.aluctr    = w_aluctr;
    w_pkt.is_mul    = w_is_mul;
    w_pkt.is_div    = w_is_div;
    w_pkt.is_ex     = ~(w_is_mul | w_is_div);
    w_pkt.csr       = w_csr;
    w_pkt.ecall     = w_ecall;
    w_pkt.ebreak    = w_ebreak;
    w_pkt.mret      = w_mret;
    // Priority: fetch fault > illegal > ebreak > ecall
    if (in_fetch_err) begin
      w_pkt.exc = 1'b1; w_pkt.exc_cause = 4'd1;
    end else if (w_illegal) begin
      w_pkt.exc = 1'b1; w_pkt.exc_cause = 4'd2;
    end else if (w_ebreak) begin
      w_pkt.exc = 1'b1; w_pkt.exc_cause = 4'd3;
    end else if (w_ecall) begin
      w_pkt.exc = 1'b1; w_pkt.exc_cause = 4'd11;
    end
  end

  // Queue storage and pointers
  pkt_t           r_mem [DEPTH];
  logic [PW-1:0]  r_head, r_tail;
  logic [CW-1:0]  r_count;
  logic           w_push, w_pop;
  pkt_t           w_head;

  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // NOTE: the packet array has no reset; every entry is qualified by the
  // reset pointers/count, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_pkt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign w_head        = r_mem[r_head];
  assign out_pc        = w_head.pc;
  assign out_imm       = w_head.imm;
  assign out_rd        = w_head.rd;
  assign out_rs1       = w_head.rs1;
  assign out_rs2       = w_head.rs2;
  assign out_regwr     = w_head.regwr;
  assign out_memrd     = w_head.memrd;
  assign out_memwr     = w_head.memwr;
  assign out_memop     = w_head.memop;
  assign out_branch    = w_head.branch;
  assign out_aluasrc   = w_head.aluasrc;
  assign out_alubsrc   = w_head.alubsrc;
  assign out_aluctr    = w_head.aluctr;
  assign out_is_mul    = w_head.is_mul;
  assign out_is_div    = w_head.is_div;
  assign out_is_ex     = w_head.is_ex;
  assign out_csr       = w_head.csr;
  assign out_ecall     = w_head.ecall;
  assign out_ebreak    = w_head.ebreak;
  assign out_mret      = w_head.mret;
  assign out_exc       = w_head.exc;
  assign out_exc_cause = w_head.exc_cause;
  assign out_count     = r_count;

  // Overflow and underflow are excluded by the handshake gating above
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && r_count == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(w_pop && r_count == '0));

endmodule

// File: tb/tb_ysyx_220066_decode_queue.sv
module tb_ysyx_220066_decode_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_fetch_err, in_csr_err, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, out_valid;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_aluctr;
  logic        out_regwr, out_memrd, out_memwr, out_aluasrc;
  logic [2:0]  out_memop, out_branch;
  logic [1:0]  out_alubsrc;
  logic        out_is_mul, out_is_div, out_is_ex, out_csr, out_ecall, out_ebreak, out_mret, out_exc;
  logic [3:0]  out_exc_cause;
  logic [2:0]  out_count;

  // Second instance with CSR checking disabled
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_pc, b_out_imm;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2, b_out_aluctr;
  logic        b_out_regwr, b_out_memrd, b_out_memwr, b_out_aluasrc;
  logic [2:0]  b_out_memop, b_out_branch;
  logic [1:0]  b_out_alubsrc;
  logic        b_out_is_mul, b_out_is_div, b_out_is_ex, b_out_csr, b_out_ecall, b_out_ebreak, b_out_mret, b_out_exc;
  logic [3:0]  b_out_exc_cause;
  logic [2:0]  b_out_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_220066_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CSR_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_fetch_err(in_fetch_err), .in_csr_err(in_csr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_regwr(out_regwr), .out_memrd(out_memrd), .out_memwr(out_memwr),
    .out_memop(out_memop), .out_branch(out_branch), .out_aluasrc(out_aluasrc),
    .out_alubsrc(out_alubsrc), .out_aluctr(out_aluctr),
    .out_is_mul(out_is_mul), .out_is_div(out_is_div), .out_is_ex(out_is_ex),
    .out_csr(out_csr), .out_ecall(out_ecall), .out_ebreak(out_ebreak), .out_mret(out_mret),
    .out_exc(out_exc), .out_exc_cause(out_exc_cause), .out_count(out_count)
  );

  ysyx_220066_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .CSR_CHECK(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_fetch_err(in_fetch_err), .in_csr_err(in_csr_err),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_imm(b_out_imm),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_regwr(b_out_regwr), .out_memrd(b_out_memrd), .out_memwr(b_out_memwr),
    .out_memop(b_out_memop), .out_branch(b_out_branch), .out_aluasrc(b_out_aluasrc),
    .out_alubsrc(b_out_alubsrc), .out_aluctr(b_out_aluctr),
    .out_is_mul(b_out_is_mul), .out_is_div(b_out_is_div), .out_is_ex(b_out_is_ex),
    .out_csr(b_out_csr), .out_ecall(b_out_ecall), .out_ebreak(b_out_ebreak), .out_mret(b_out_mret),
    .out_exc(b_out_exc), .out_exc_cause(b_out_exc_cause), .out_count(b_out_count)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        ferr, cerr;
    logic        exc;
    logic [3:0]  cause;
    logic        regwr, memrd, memwr;
    logic [2:0]  branch;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [4:0]  aluctr;
    logic        ebreak, ecall, mret, is_mul, is_div, csr;
    logic        exc_nochk;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with optional push and/or pop, then both strobes drop
  task automatic cycle(input logic push, input logic [63:0] pc, input logic [31:0] instr,
                       input logic pop);
    in_valid  = push;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = pop;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //            name          instr         pc             fe cr exc cause rw mr mw br      rd  imm                    alu  eb ec mr mul div csr nochk
    vecs.push_back('{"addi",      32'h00500093, 64'h80000000, 0, 0, 0, 4'd0,  1, 0, 0, 3'b000, 1,  64'd5,                 5'd0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"ill_ff",    32'hFFFFFFFF, 64'h80000004, 0, 0, 1, 4'd2,  0, 0, 0, 3'b000, 31, 64'hFFFFFFFFFFFFFFFF,  5'd0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{"ebreak",    32'h00100073, 64'h80000008, 0, 0, 1, 4'd3,  0, 0, 0, 3'b000, 0,  64'd1,                 5'd0, 1, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{"ecall",     32'h00000073, 64'h8000000C, 0, 0, 1, 4'd11, 0, 0, 0, 3'b000, 0,  64'd0,                 5'd0, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{"mret",      32'h30200073, 64'h80000010, 0, 0, 0, 4'd0,  0, 0, 0, 3'b000, 0,  64'h302,               5'd0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{"wfi_ill",   32'h10500073, 64'h80000014, 0, 0, 1, 4'd2,  0, 0, 0, 3'b000, 0,  64'h105,               5'd0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{"ferr_addi", 32'h00500093, 64'h80000018, 1, 0, 1, 4'd1,  0, 0, 0, 3'b000, 1,  64'd5,                 5'd0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{"sd",        32'h0020B423, 64'h8000001C, 0, 0, 0, 4'd0,  0, 0, 1, 3'b000, 8,  64'd8,                 5'd0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"ferr_sd",   32'h0020B423, 64'h80000020, 1, 0, 1, 4'd1,  0, 0, 0, 3'b000, 8,  64'd8,                 5'd0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{"csrrw",     32'h300110F3, 64'h80000024, 0, 0, 0, 4'd0,  1, 0, 0, 3'b000, 1,  64'h300,               5'd0, 0, 0, 0, 0, 0, 1, 0});
    vecs.push_back('{"csrrw_err", 32'h300110F3, 64'h80000028, 0, 1, 1, 4'd2,  0, 0, 0, 3'b000, 1,  64'h300,               5'd0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"jal",       32'h008000EF, 64'h8000002C, 0, 0, 0, 4'd0,  1, 0, 0, 3'b001, 1,  64'd8,                 5'd0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"beq_neg",   32'hFE208EE3, 64'h80000030, 0, 0, 0, 4'd0,  0, 0, 0, 3'b100, 29, 64'hFFFFFFFFFFFFFFFC,  5'd1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"lui_neg",   32'h800002B7, 64'h80000034, 0, 0, 0, 4'd0,  1, 0, 0, 3'b000, 5,  64'hFFFFFFFF80000000,  5'd10,0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"ld_neg",    32'hFF813183, 64'h80000038, 0, 0, 0, 4'd0,  1, 1, 0, 3'b000, 3,  64'hFFFFFFFFFFFFFFF8,  5'd0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"mul",       32'h023100B3, 64'h8000003C, 0, 0, 0, 4'd0,  1, 0, 0, 3'b000, 1,  64'd35,                5'd0, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{"div",       32'h023140B3, 64'h80000040, 0, 0, 0, 4'd0,  1, 0, 0, 3'b000, 1,  64'd35,                5'd4, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{"sub",       32'h403100B3, 64'h80000044, 0, 0, 0, 4'd0,  1, 0, 0, 3'b000, 1,  64'h403,               5'd1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"low_bits",  32'h00500090, 64'h80000048, 0, 0, 1, 4'd2,  0, 0, 0, 3'b000, 1,  64'd5,                 5'd0, 0, 0, 0, 0, 0, 0, 1});

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fetch_err = 1'b0; in_csr_err = 1'b0; in_instr = '0; in_pc = '0;
    #12 rst = 1'b0;
    tick();

    // Reset state
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_count", 64'(out_count), 64'd0);

    // Table: push one packet, inspect the head one cycle later, then pop it
    foreach (vecs[i]) begin
      in_fetch_err = vecs[i].ferr;
      in_csr_err   = vecs[i].cerr;
      cycle(1'b1, vecs[i].pc, vecs[i].instr, 1'b0);
      in_fetch_err = 1'b0;
      in_csr_err   = 1'b0;
      check({vecs[i].name, ".valid"},  64'(out_valid),  64'd1);
      check({vecs[i].name, ".count"},  64'(out_count),  64'd1);
      check({vecs[i].name, ".pc"},     out_pc,          vecs[i].pc);
      check({vecs[i].name, ".exc"},    64'(out_exc),    64'(vecs[i].exc));
      if (vecs[i].exc)
        check({vecs[i].name, ".cause"}, 64'(out_exc_cause), 64'(vecs[i].cause));
      check({vecs[i].name, ".regwr"},  64'(out_regwr),  64'(vecs[i].regwr));
      check({vecs[i].name, ".memrd"},  64'(out_memrd),  64'(vecs[i].memrd));
      check({vecs[i].name, ".memwr"},  64'(out_memwr),  64'(vecs[i].memwr));
      check({vecs[i].name, ".branch"}, 64'(out_branch), 64'(vecs[i].branch));
      check({vecs[i].name, ".rd"},     64'(out_rd),     64'(vecs[i].rd));
      check({vecs[i].name, ".imm"},    out_imm,         vecs[i].imm);
      check({vecs[i].name, ".aluctr"}, 64'(out_aluctr), 64'(vecs[i].aluctr));
      check({vecs[i].name, ".ebreak"}, 64'(out_ebreak), 64'(vecs[i].ebreak));
      check({vecs[i].name, ".ecall"},  64'(out_ecall),  64'(vecs[i].ecall));
      check({vecs[i].name, ".mret"},   64'(out_mret),   64'(vecs[i].mret));
      check({vecs[i].name, ".is_mul"}, 64'(out_is_mul), 64'(vecs[i].is_mul));
      check({vecs[i].name, ".is_div"}, 64'(out_is_div), 64'(vecs[i].is_div));
      check({vecs[i].name, ".csr"},    64'(out_csr),    64'(vecs[i].csr));
      check({vecs[i].name, ".exc_nochk"}, 64'(b_out_exc), 64'(vecs[i].exc_nochk));
      cycle(1'b0, '0, '0, 1'b1);
      check({vecs[i].name, ".drained"}, 64'(out_count), 64'd0);
    end

    // Fill with backpressure, then a push while full is refused
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 64'h1000 + 64'(4 * i), 32'h00500093, 1'b0);
      check("fill.count", 64'(out_count), 64'(i + 1));
    end
    check("fill.in_ready", 64'(in_ready), 64'd0);
    check("fill.head_pc",  out_pc, 64'h1000);
    cycle(1'b1, 64'hBAD0, 32'h00500093, 1'b0);
    check("full_push.count", 64'(out_count), 64'd4);
    // Full with a concurrent pop: no pass-through enqueue
    cycle(1'b1, 64'hBAD4, 32'h00500093, 1'b1);
    check("full_pop.count", 64'(out_count), 64'd3);
    check("full_pop.in_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i < DEPTH; i++) begin
      check("drain.pc", out_pc, 64'h1000 + 64'(4 * i));
      cycle(1'b0, '0, '0, 1'b1);
    end
    check("drain.valid", 64'(out_valid), 64'd0);
    // Second round exercises pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'h2000 + 64'(4 * i), 32'h00500093, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("wrap.pc", out_pc, 64'h2000 + 64'(4 * i));
      cycle(1'b0, '0, '0, 1'b1);
    end
    check("wrap.count", 64'(out_count), 64'd0);

    // Simultaneous push and pop at count 2
    cycle(1'b1, 64'h3000, 32'h00500093, 1'b0);
    cycle(1'b1, 64'h3004, 32'h00500093, 1'b0);
    cycle(1'b1, 64'h3008, 32'h00500093, 1'b1);
    check("pushpop.count", 64'(out_count), 64'd2);
    check("pushpop.head",  out_pc, 64'h3004);
    cycle(1'b0, '0, '0, 1'b1);
    check("pushpop.next",  out_pc, 64'h3008);
    cycle(1'b0, '0, '0, 1'b1);
    check("pushpop.empty", 64'(out_count), 64'd0);

    // Flush with three queued entries and a concurrent push
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h4000 + 64'(4 * i), 32'h00500093, 1'b0);
    flush = 1'b1;
    cycle(1'b1, 64'h400C, 32'h00500093, 1'b1);
    flush = 1'b0;
    check("flush.valid",    64'(out_valid), 64'd0);
    check("flush.count",    64'(out_count), 64'd0);
    check("flush.in_ready", 64'(in_ready),  64'd1);
    cycle(1'b1, 64'h5000, 32'h00500093, 1'b0);
    check("flush.new_head", out_pc, 64'h5000);
    check("flush.new_count", 64'(out_count), 64'd1);
    cycle(1'b0, '0, '0, 1'b1);

    // Asynchronous reset between edges while three entries are queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h6000 + 64'(4 * i), 32'h00500093, 1'b0);
    check("arst.pre_count", 64'(out_count), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.count", 64'(out_count), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();
    check("arst.after_count", 64'(out_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_decode_queue.md
Name: ysyx_220066_decode_queue

Overview:
Parametrised decode stage for the RV64IM pipeline. It replaces the single pipeline register and `block` stall with a DEPTH-entry queue of fully decoded instruction packets, using valid/ready handshakes on both sides.
- Decode happens at enqueue, so EX reads a pre-decoded packet directly from the queue head.
- Adds a flush, exception-cause encoding and an occupancy output.
- Sits between IF and EX/regfile read.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, ≥2.
- XLEN, 64, PC and immediate width.
- CSR_CHECK, 1, when 1 the `in_csr_err` input is honoured; when 0 it is ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- flush  in  1  synchronous flush; drops all entries and any same-cycle enqueue.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  queue can accept (= !full).
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of `in_instr`.
- in_fetch_err  in  1  fetch access fault.
- in_csr_err  in  1  addressed CSR is nonexistent or read-only.
- out_valid  out  1  head entry valid (= count!=0).
- out_ready  in  1  EX consumes the head.
- out_pc  out  XLEN  head PC.
- out_imm  out  XLEN  32-bit immediate from the existing IMM encoding (I=000, U=101, B=011, S=010, J=001), sign-extended to XLEN.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- out_regwr, out_memrd, out_memwr  out  1 each  control bits.
- out_memop  out  3  funct3.
- out_branch  out  3  branch code (000 none, 001 jal, 010 jalr, 1xx conditional).
- out_aluasrc  out  1  ALU A source.
- out_alubsrc  out  2  ALU B source.
- out_aluctr  out  5  ALU op.
- out_is_mul, out_is_div, out_is_ex  out  1 each  execution-unit select.
- out_csr, out_ecall, out_ebreak, out_mret  out  1 each  system-instruction flags.
- out_exc  out  1  head carries an exception.
- out_exc_cause  out  4  mcause code, valid when `out_exc`=1.
- out_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- **Decode (combinational on `in_*`):**
  - Field encodings and the illegal-instruction rules are identical to the team's RV64IM decoder, including: opcode[1:0]!=11 is illegal; system funct3=000 is legal only for 0x00000073, 0x00100073 and 0x30200073.
  - `out_ebreak` = instr==0x00100073; `out_ecall` = instr==0x00000073; `out_mret` = instr==0x30200073.
  - CSR funct3!=000 with `in_csr_err`=1 (and CSR_CHECK=1) is illegal.
- **Exception priority:** `in_fetch_err` (cause 1) > illegal (cause 2) > ebreak (cause 3) > ecall (cause 11).
  - `exc` = any of the above.
  - When `in_fetch_err`=1, the decoded control bits are forced to 0: `regwr`, `memrd`, `memwr`, `branch`.
- **Storage:** circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap naturally, plus count.
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- **Per edge:**
  - push writes the packet at tail and increments tail.
  - pop increments head.
  - count += push - pop; push and pop together leave count unchanged.
- **in_ready:** = count<DEPTH. When full, no enqueue happens even if a pop occurs that cycle (no pass-through).
- **Latency:** an instruction accepted at edge N appears at `out_*` after edge N (1 cycle). There is no empty bypass.
- **Outputs:** all `out_*` packet fields are driven from the head entry register. They hold steady while out_valid=1 and out_ready=0. They are don't-care when out_valid=0.
- **flush:** at the next edge, head=tail=count=0; the concurrent push and pop are discarded. in_ready=1 in the following cycle.
- **rst:** asynchronous and immediate.
  - head=tail=count=0, so out_valid=0, in_ready=1, out_count=0.
  - Storage array is not reset; all packet fields in the array are qualified by valid.
  - Reset mid-transfer drops all entries, including any in-flight push.
- **Simulation guard:** a push while full, or a pop while empty, must be impossible by construction; an assertion flags it.

Test Plan:
- **Reset and single entry:** assert rst, then push 0x00500093 (addi x1,x0,5) at pc 0x80000000 → next cycle out_valid=1, out_rd=1, out_imm=5, out_regwr=1, out_aluctr=00000, out_exc=0, out_count=1.
- **Fill and backpressure:** hold out_ready=0 and push DEPTH instructions → in_ready=0 after the DEPTH-th push; a further in_valid is ignored. Then set out_ready=1 → entries emerge in FIFO order with correct pc; pointers wrap after 2*DEPTH pushes.
- **Simultaneous push/pop:** with count=2, push and pop in the same cycle → out_count stays 2, order is preserved.
- **Exceptions:**
  - 0xFFFFFFFF → out_exc=1, cause=2.
  - 0x00100073 → cause=3, out_ebreak=1.
  - 0x00000073 → cause=11.
  - in_fetch_err=1 with any instruction → cause=1, out_regwr=0, out_memwr=0.
  - csrrw with in_csr_err=1 → cause=2; with CSR_CHECK=0 → out_exc=0.
- **Flush:** with 3 entries queued plus a push in the same cycle as flush=1 → next cycle out_valid=0, out_count=0, in_ready=1; the flushed instructions never appear.
- **Async reset mid-operation:** pulse rst between edges while count=3 → out_valid=0 and out_count=0 immediately, before the next clk edge.
